// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// The master drives request and address, and the slave returns grant and in-order response data.
interface fetch_unit_if #(
    parameter int IW = 20,
    parameter int AW = 15
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: issues one instruction fetch at a time to imem and buffers responses in a small FIFO.
// The FIFO feeds Decode. An Execute redirect flushes the FIFO and discards any in-flight response.
module fetch_unit #(
    parameter int          IW       = 20,
    parameter int          AW       = 15,
    parameter int          DEPTH    = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PCSrcE,
    input  logic [AW-1:0] PCTargetE,
    input  logic          StallD,
    fetch_unit_if.master  imem,
    output logic [IW-1:0] InstrD,
    output logic [AW-1:0] PCD,
    output logic [AW-1:0] PCPlus1D,
    output logic          ValidD
);

    localparam int             PW         = $clog2(DEPTH);
    localparam int             CW         = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [PW-1:0]  PTR_ZERO   = {PW{1'b0}};
    localparam logic [PW-1:0]  PTR_ONE    = PW'(1);
    localparam logic [AW-1:0]  PC_ZERO    = {AW{1'b0}};
    localparam logic [AW-1:0]  PC_ONE     = AW'(1);
    localparam logic [AW-1:0]  RESET_PC_C = AW'(RESET_PC);
    localparam logic [IW-1:0]  INSTR_ZERO = {IW{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [AW-1:0] pcf_r;
    logic [AW-1:0] pend_pc_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [IW-1:0] instr_q_r [DEPTH];
    logic [AW-1:0] pc_q_r    [DEPTH];

    logic req_s;
    logic fire_s;
    logic push_s;
    logic pop_s;
    logic valid_s;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state and request decode; a redirect suppresses new requests and drops queued responses
    always_comb begin
        state_nx_s = state_r;
        req_s      = 1'b0;
        push_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if ((count_r < DEPTH_C) && !PCSrcE) begin
                    req_s = 1'b1;
                end else begin
                    req_s = 1'b0;
                end
                if (req_s && imem.imem_gnt) begin
                    state_nx_s = S_WAIT;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    push_s     = !PCSrcE;
                    state_nx_s = S_IDLE;
                end else if (PCSrcE) begin
                    state_nx_s = S_DROP;
                end else begin
                    state_nx_s = S_WAIT;
                end
            end
            S_DROP: begin
                if (imem.imem_rvalid) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_DROP;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    assign fire_s  = req_s && imem.imem_gnt;
    assign valid_s = (count_r != CNT_ZERO);
    assign pop_s   = valid_s && !StallD && !PCSrcE;

    // Fetch PC and the PC of the single outstanding request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcf_r     <= RESET_PC_C;
            pend_pc_r <= PC_ZERO;
        end else if (PCSrcE) begin
            pcf_r     <= PCTargetE;
        end else if (fire_s) begin
            pcf_r     <= pcf_r + PC_ONE;
            pend_pc_r <= pcf_r;
        end
    end

    // Queue occupancy and pointers; a flush realigns both pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r  <= CNT_ZERO;
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
        end else if (PCSrcE) begin
            count_r  <= CNT_ZERO;
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q_r[i] <= INSTR_ZERO;
                pc_q_r[i]    <= PC_ZERO;
            end
        end else if (push_s) begin
            instr_q_r[wr_ptr_r] <= imem.imem_rdata;
            pc_q_r[wr_ptr_r]    <= pend_pc_r;
        end
    end

    assign imem.imem_req  = req_s;
    assign imem.imem_addr = pcf_r;

    // Head-of-queue view is read from registers only and is zero when the queue is empty
    assign ValidD   = valid_s;
    assign InstrD   = valid_s ? instr_q_r[rd_ptr_r] : INSTR_ZERO;
    assign PCD      = valid_s ? pc_q_r[rd_ptr_r] : PC_ZERO;
    assign PCPlus1D = valid_s ? (pc_q_r[rd_ptr_r] + PC_ONE) : PC_ZERO;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter IW, default 20, meaning instruction width in bits.
REQ-002 The block SHALL have parameter AW, default 15, meaning PC/address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning fetch-queue entries (power of two, >=2).
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 PCSrcE  in  1  redirect request from Execute.
REQ-008 PCTargetE  in  AW  redirect target PC.
REQ-009 StallD  in  1  Decode cannot accept the head entry this cycle.
REQ-010 imem_req  out  1  fetch request to instruction memory.
REQ-011 imem_addr  out  AW  fetch address, valid while imem_req=1.
REQ-012 imem_gnt  in  1  memory accepts the request this cycle.
REQ-013 imem_rvalid  in  1  response data valid (in order, latency >=1 cycle after grant).
REQ-014 imem_rdata  in  IW  response instruction word.
REQ-015 InstrD  out  IW  instruction at queue head.
REQ-016 PCD  out  AW  PC of InstrD.
REQ-017 PCPlus1D  out  AW  PCD+1.
REQ-018 ValidD  out  1  head entry valid.

Function
REQ-019 State machine SHALL have states IDLE (no outstanding request), WAIT (one request outstanding), DROP (one outstanding request to be discarded); at most one request outstanding at any time.
REQ-020 In IDLE, imem_req SHALL be 1 iff count<DEPTH and PCSrcE=0; imem_addr SHALL equal PCF.
REQ-021 imem_req=1 with imem_gnt=1 SHALL capture pend_pc<=PCF, PCF<=PCF+1 (mod 2^AW), and move IDLE->WAIT; with imem_gnt=0, request and address SHALL be held unchanged next cycle.
REQ-022 In WAIT, imem_rvalid=1 SHALL push {imem_rdata, pend_pc} into the queue and move to IDLE; no new request SHALL issue that same cycle.
REQ-023 In WAIT/DROP imem_req SHALL be 0.
REQ-024 In DROP, imem_rvalid=1 SHALL discard the response and move to IDLE.
REQ-025 PCSrcE=1 SHALL have highest priority: PCF<=PCTargetE, queue emptied (count<=0), WAIT->DROP, DROP stays DROP, IDLE stays IDLE; any response arriving that same cycle SHALL be discarded (WAIT->IDLE if imem_rvalid=1).
REQ-026 Pop SHALL occur when ValidD=1, StallD=0 and PCSrcE=0; push and pop in the same cycle SHALL leave count unchanged.
REQ-027 A push SHALL never find the queue full (guaranteed by REQ-020 gating); count SHALL range 0..DEPTH using ceil(log2(DEPTH))+1 bits, pointers wrapping modulo DEPTH.
REQ-028 ValidD SHALL be 1 iff count>0; InstrD/PCD SHALL be the head entry, PCPlus1D=PCD+1 mod 2^AW; when count=0 InstrD, PCD and PCPlus1D SHALL be 0.
REQ-029 Outputs SHALL be registered-state derived (no combinational path from imem_rdata to InstrD); minimum fetch-to-ValidD latency is 1 cycle after imem_rvalid.
REQ-030 PCF SHALL wrap from 2^AW-1 to 0 without error.

Reset
REQ-031 reset=0 SHALL immediately force: state IDLE, PCF=RESET_PC, count=0, pointers=0, pend_pc=0, ValidD=0, InstrD=0, PCD=0, PCPlus1D=0; imem_req=1 from first cycle after release.
REQ-032 A reset asserted while WAIT SHALL abandon the outstanding request; responses arriving in IDLE SHALL be ignored.

Verification
REQ-033 Reset release, imem_gnt=1, 1-cycle latency, rdata=20'hA5A5A -> imem_addr=0, then ValidD=1, InstrD=20'hA5A5A, PCD=0, PCPlus1D=1; next request addr=1.
REQ-034 StallD=1 held, DEPTH=2 -> after two pushes imem_req stays 0; release StallD -> entries pop in PC order 0,1 and requests resume at 2.
REQ-035 PCSrcE=1, PCTargetE=15'h0100 while WAIT -> queue empties, ValidD=0, late response discarded, next imem_addr=15'h0100.
REQ-036 PCSrcE=1 in the same cycle as imem_rvalid=1 -> response discarded, state IDLE, ValidD=0 next cycle.
REQ-037 Start at PCF=15'h7FFF -> fetched PCD=15'h7FFF, PCPlus1D=0, next imem_addr=0.
REQ-038 reset=0 mid-WAIT with 2 valid entries -> ValidD=0 and all outputs 0 without waiting for clk; post-release imem_addr=RESET_PC.
